// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions used by the fetch stage.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- what decode sees when no fetched instruction is presented
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    // One buffered fetch result: the instruction and the PC it was fetched from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Instructions are word aligned; low address bits of a target are ignored
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush. Push while full is accepted only when a
// pop happens on the same edge; pop while empty is ignored.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, issues in-order requests to instruction memory,
// buffers {pc, inst} pairs for decode and discards stale responses on redirect.
//
// Handshakes: an imem request transfers on a cycle with imem_req && imem_gnt;
// imem_addr holds while imem_req is high and not granted. imem_rvalid carries
// the response to the oldest granted request. Decode consumes the presented
// entry on a cycle with ValidF && !StallF.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_data,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] InstF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = $bits(fetch_entry_t);

    logic [31:0]   req_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] outstanding_next;
    logic [OW-1:0] kill;

    logic          accept;
    logic          rv_eff;
    logic          pop;
    logic          buf_push;
    logic [31:0]   slots_in_use;
    logic          credit_ok;

    logic [EW-1:0] buf_head;
    logic [BW-1:0] buf_count;
    logic          buf_full;
    logic          buf_empty;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    logic [31:0]   pcq_head;
    logic [OW-1:0] pcq_count;
    logic          pcq_full;
    logic          pcq_empty;

    // A response with nothing outstanding is a protocol error and is ignored
    assign rv_eff = imem_rvalid && (outstanding != '0);
    assign pop    = !buf_empty && !StallF && !PCSrcE;

    // Buffer slots are reserved at request time. The head leaving this cycle
    // frees its slot immediately, which sustains one instruction per cycle.
    assign slots_in_use = 32'(outstanding) + 32'(buf_count) - 32'(pop);
    assign credit_ok    = (slots_in_use < 32'(FIFO_DEPTH))
                       && (outstanding < OW'(MAX_OUTSTANDING));

    assign imem_req  = !rst && !PCSrcE && credit_ok;
    assign imem_addr = req_pc;
    assign accept    = imem_req && imem_gnt;

    assign outstanding_next = outstanding + OW'(accept) - OW'(rv_eff);

    // Killed responses are popped from the PC queue but never reach the buffer
    assign buf_push        = rv_eff && (kill == '0) && !PCSrcE;
    assign push_entry.pc   = pcq_head;
    assign push_entry.inst = imem_data;

    // PCs of accepted requests, matched in order to returning data
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING),
        .CW    (OW)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (accept),
        .push_data (req_pc),
        .pop       (rv_eff),
        .head_data (pcq_head),
        .count     (pcq_count),
        .full      (pcq_full),
        .empty     (pcq_empty)
    );

    // Fetched instructions waiting for decode
    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH),
        .CW    (BW)
    ) u_fetch_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (PCSrcE),
        .push      (buf_push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign head     = buf_head;
    assign ValidF   = !buf_empty;
    assign InstF    = ValidF ? head.inst : NOP_INST;
    assign PCF      = ValidF ? head.pc : 32'h0;
    assign PCPlus4F = ValidF ? head.pc + 32'd4 : 32'h0;

    // Fetch PC, in-flight count and stale-response counter
    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc      <= RESET_PC;
            outstanding <= '0;
            kill        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (PCSrcE) begin
                req_pc <= word_align(PCTargetE);
                kill   <= outstanding_next;
            end else begin
                if (accept) req_pc <= req_pc + 32'd4;
                if (rv_eff && (kill != '0)) kill <= kill - 1'b1;
            end
        end
    end

    a_rvalid_with_request: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && (outstanding == '0)));

    a_pc_queue_tracks: assert property (@(posedge clk) disable iff (rst)
        (pcq_count == outstanding) && (pcq_empty == (outstanding == '0)));

    a_pc_queue_room: assert property (@(posedge clk) disable iff (rst)
        !(accept && pcq_full && !rv_eff));

    a_buf_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(buf_push && buf_full && !pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order imem model with programmable
// latency and grant, an expected-PC queue for everything decode consumes,
// and point checks around reset, stall, grant backpressure and redirects.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_data;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        ValidF;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic        gnt_on   = 1'b1;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] exp_q[$];

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_data   (imem_data),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .InstF       (InstF),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .ValidF      (ValidF)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_stream(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Drive memory-side inputs for this cycle, let outputs settle, score a pop
    task automatic start_cycle();
        logic [31:0] e;
        imem_gnt    = gnt_on;
        imem_rvalid = 1'b0;
        imem_data   = 32'h0;
        if (!rst && pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_data   = mem_word(pend_addr[0]);
        end
        #1;
        if (!rst && !PCSrcE && !StallF && ValidF === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pop", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_pcf", PCF, e);
                check("sb_inst", InstF, mem_word(e));
                check("sb_pc4", PCPlus4F, e + 32'd4);
            end
        end
    endtask

    // Record the transfers of this cycle in the memory model, advance a cycle
    task automatic end_cycle();
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
        end else begin
            if (imem_rvalid) begin
                pend_addr.delete(0);
                pend_due.delete(0);
            end
            if (imem_req === 1'b1 && imem_gnt) begin
                pend_addr.push_back(imem_addr);
                pend_due.push_back(cyc + lat);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            start_cycle();
            end_cycle();
        end
    endtask

    // Leaves the caller inside the first cycle with ValidF high
    task automatic wait_valid(input int limit, output int n);
        n = 0;
        start_cycle();
        while (ValidF !== 1'b1 && n < limit) begin
            end_cycle();
            n++;
            start_cycle();
        end
        if (ValidF !== 1'b1) check("valid_timeout", 32'(ValidF), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_data = 32'h0;

        // Reset, zero-latency memory, straight-line fetch
        start_cycle(); check("rst_req", 32'(imem_req), 32'd0); end_cycle();
        start_cycle();
        check("rst_valid", 32'(ValidF), 32'd0);
        check("rst_inst", InstF, 32'h0000_0013);
        check("rst_pcf", PCF, 32'h0);
        check("rst_pc4", PCPlus4F, 32'h0);
        end_cycle();
        rst = 1'b0;
        expect_stream(32'h0, 64);
        start_cycle();
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        check("c0_valid", 32'(ValidF), 32'd0);
        end_cycle();
        start_cycle(); check("c1_valid", 32'(ValidF), 32'd0); end_cycle();
        start_cycle(); check("c2_valid", 32'(ValidF), 32'd1); end_cycle();
        run(3);

        // Decode stall: requests stop, presented entry frozen
        StallF = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start_cycle();
            check("stall_valid", 32'(ValidF), 32'd1);
            check("stall_req", 32'(imem_req), 32'd0);
            check("stall_pcf", PCF, exp_q[0]);
            end_cycle();
        end
        StallF = 1'b0;
        run(4);

        // Redirect with a response arriving and the head leaving this cycle,
        // then grant held low while the request is pending
        PCSrcE = 1'b1; PCTargetE = 32'h10;
        start_cycle(); check("redir_had_valid", 32'(ValidF), 32'd1); end_cycle();
        PCSrcE = 1'b0;
        expect_stream(32'h10, 64);
        gnt_on = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start_cycle();
            check("nognt_req", 32'(imem_req), 32'd1);
            check("nognt_addr", imem_addr, 32'h10);
            check("nognt_valid", 32'(ValidF), 32'd0);
            end_cycle();
        end
        gnt_on = 1'b1;
        wait_valid(20, n);
        check("resume_lat", 32'(n), 32'd2);
        check("resume_pcf", PCF, 32'h10);
        end_cycle();
        run(4);

        // Reset mid-stream, then latency-3 memory with two stale requests
        lat = 3;
        rst = 1'b1;
        start_cycle(); check("mid_rst_req", 32'(imem_req), 32'd0); end_cycle();
        start_cycle();
        check("mid_rst_valid", 32'(ValidF), 32'd0);
        check("mid_rst_req2", 32'(imem_req), 32'd0);
        check("mid_rst_inst", InstF, 32'h0000_0013);
        end_cycle();
        rst = 1'b0;
        exp_q.delete();
        start_cycle(); check("l3_c0_addr", imem_addr, 32'h0); check("l3_c0_req", 32'(imem_req), 32'd1); end_cycle();
        start_cycle(); check("l3_c1_addr", imem_addr, 32'h4); check("l3_c1_req", 32'(imem_req), 32'd1); end_cycle();
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        start_cycle(); check("l3_redir_req", 32'(imem_req), 32'd0); end_cycle();
        PCSrcE = 1'b0;
        expect_stream(32'h100, 64);
        wait_valid(20, n);
        check("l3_lat", 32'(n), 32'd5);
        check("l3_pcf", PCF, 32'h100);
        check("l3_inst", InstF, mem_word(32'h100));
        end_cycle();
        run(4);

        // Unaligned target and PC wrap, back on zero-latency memory
        lat = 1;
        PCSrcE = 1'b1; PCTargetE = 32'h103;
        start_cycle(); end_cycle();
        PCSrcE = 1'b0;
        expect_stream(32'h100, 64);
        start_cycle(); check("align_addr", imem_addr, 32'h100); end_cycle();
        wait_valid(20, n);
        check("align_pcf", PCF, 32'h100);
        end_cycle();
        run(2);

        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        start_cycle(); end_cycle();
        PCSrcE = 1'b0;
        expect_stream(32'hFFFF_FFFC, 64);
        start_cycle(); check("wrap_addr", imem_addr, 32'hFFFF_FFFC); end_cycle();
        wait_valid(20, n);
        check("wrap_pcf", PCF, 32'hFFFF_FFFC);
        check("wrap_pc4", PCPlus4F, 32'h0);
        end_cycle();
        run(4);
        check("wrap_consumed", 32'(exp_q.size()), 32'd59);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop if something above loops without bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
